// File: rtl/sum_unit_arbiter_pkg.sv
// Shared definitions for the summing-unit arbiter slice.
//   - FSM state encodings (kept as plain 2-bit constants for compatibility
//     with older blocks that decode the state bus directly).
//   - Default widths and timing parameters used by the interface and top.
package sum_arb_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ISSUE   = 2'b01;
  localparam logic [1:0] WAIT    = 2'b10;
  localparam logic [1:0] RESPOND = 2'b11;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_IDX_W   = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RES_W   = 10;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_TMO_W   = 5;

endpackage

// File: rtl/sum_unit_arbiter_if.sv
// Bundle of every signal between the arbiter, its requesters and the single
// summing unit.
//   slave  : the arbiter's view (drives done/resp/busy/grant/dev_* outputs).
//   master : the environment's view (requesters plus the summing unit).
//
// Handshake:
//   Requester i raises req[i] with its word on req_data[i*DATA_W +: DATA_W]
//   and holds both stable until it sees done[i] for one cycle; it may drop
//   req at the clock edge that ends the done cycle. The arbiter forwards the
//   word on dev_data with a one-cycle dev_start pulse; the unit answers with
//   a one-cycle dev_valid carrying dev_result. Neither side back-pressures.
//   state exposes the arbiter FSM for observation.
interface sum_unit_arbiter_if
  import sum_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        done;
  logic [RES_W-1:0]        resp_result;
  logic                    resp_error;
  logic                    busy;
  logic [IDX_W-1:0]        grant_id;
  logic                    dev_start;
  logic [DATA_W-1:0]       dev_data;
  logic                    dev_valid;
  logic [RES_W-1:0]        dev_result;
  logic [1:0]              state;

  modport slave (
    input  req, req_data, dev_valid, dev_result,
    output done, resp_result, resp_error, busy, grant_id,
           dev_start, dev_data, state
  );

  modport master (
    output req, req_data, dev_valid, dev_result,
    input  done, resp_result, resp_error, busy, grant_id,
           dev_start, dev_data, state
  );

endinterface

// File: rtl/sum_unit_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   eligible : requesters that may be granted this cycle
//   ptr      : index that has top priority
//   any      : at least one eligible requester
//   idx      : first eligible index scanning ptr, ptr+1, ... mod N_REQ
// The request vector is rotated so ptr lands at bit 0, the lowest set bit is
// found, and the offset is added back to ptr.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // rotated[k] == eligible[(ptr + k) mod N_REQ]
  assign doubled = {eligible, eligible};
  assign rotated = doubled[ptr +: N_REQ];
  assign any     = |eligible;

  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) off = IDX_W'(k);
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/sum_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x8-bit summing unit among
// N_REQ requesters. Latches the granted requester's word, pulses the unit's
// start, waits for its valid (with a timeout guard) and returns the sum or
// an error to the requester with a one-cycle done pulse.
//   clk          : clock, rising edge
//   async_reset  : asynchronous, active-low reset
//   bus (slave)  : requester and summing-unit signals, see sum_unit_arbiter_if
// All outputs are registered.
module sum_unit_arbiter
  import sum_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMO_W   = DEF_TMO_W
) (
  input logic             clk,
  input logic             async_reset,
  sum_unit_arbiter_if.slave bus
);

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [N_REQ-1:0]  last_mask;

  logic [N_REQ-1:0]  done_q;
  logic [RES_W-1:0]  resp_result_q;
  logic              resp_error_q;
  logic              busy_q;
  logic [IDX_W-1:0]  grant_id_q;
  logic              dev_start_q;
  logic [DATA_W-1:0] dev_data_q;

  logic [N_REQ-1:0]  eligible;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_word;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // The requester just served may still show req for one cycle after its
  // done; last_mask hides it for exactly that IDLE cycle.
  assign eligible = bus.req & ~last_mask;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_word = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      tmo_cnt       <= '0;
      last_mask     <= '0;
      done_q        <= '0;
      resp_result_q <= '0;
      resp_error_q  <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      dev_start_q   <= 1'b0;
      dev_data_q    <= '0;
    end else begin
      // Single-cycle pulses default low.
      dev_start_q <= 1'b0;
      done_q      <= '0;
      case (state)
        IDLE: begin
          last_mask <= '0;
          if (pick_any) begin
            grant_id_q  <= pick_idx;
            dev_data_q  <= pick_word;
            busy_q      <= 1'b1;
            // Raised here so the pulse is visible during ISSUE.
            dev_start_q <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A valid arriving together with the last timeout cycle wins.
          if (bus.dev_valid) begin
            resp_result_q <= bus.dev_result;
            resp_error_q  <= 1'b0;
            done_q        <= onehot(grant_id_q);
            state         <= RESPOND;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            resp_result_q <= '0;
            resp_error_q  <= 1'b1;
            done_q        <= onehot(grant_id_q);
            state         <= RESPOND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr    <= (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          last_mask <= onehot(grant_id_q);
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.dev_start   = dev_start_q;
  assign bus.dev_data    = dev_data_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_sum_unit_arbiter.sv
// Directed testbench for sum_unit_arbiter. The summing unit is modelled in
// the bench: dev_valid arrives 5 cycles after dev_start with the byte sum.
module tb_sum_unit_arbiter;
  import sum_arb_pkg::*;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int DATA_W = 32;
  localparam int RES_W  = 10;

  logic clk;
  logic async_reset;

  sum_unit_arbiter_if #(
    .N_REQ(N_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .RES_W(RES_W)
  ) bus ();

  sum_unit_arbiter dut (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  // ---------------- summing unit model ----------------
  bit model_on = 1'b1;
  int m_cnt    = 0;

  always @(negedge clk or negedge async_reset) begin
    if (!async_reset) begin
      m_cnt          = 0;
      bus.dev_valid  = 1'b0;
      bus.dev_result = '0;
    end else begin
      if (bus.dev_valid) bus.dev_valid = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.dev_valid  = 1'b1;
          bus.dev_result = 10'(bus.dev_data[7:0]) + 10'(bus.dev_data[15:8])
                         + 10'(bus.dev_data[23:16]) + 10'(bus.dev_data[31:24]);
        end
      end
      if (bus.dev_start && model_on) m_cnt = 5;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [IDX_W-1:0]  start_q[$];
  logic [IDX_W-1:0]  exp_q[$];
  int                start_cnt  = 0;
  int                start_cyc  = 0;
  logic [DATA_W-1:0] start_data = '0;
  int                done_cnt   = 0;

  always @(negedge clk) begin
    if (bus.dev_start) begin
      start_cnt++;
      start_cyc  = cyc;
      start_data = bus.dev_data;
      start_q.push_back(bus.grant_id);
    end
    if (bus.done != '0) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    async_reset = 1'b0;
    repeat (3) @(negedge clk);
    async_reset = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok,
                           output logic [N_REQ-1:0] d, output logic [RES_W-1:0] r,
                           output logic e, output int c);
    ok = 1'b0; d = '0; r = '0; e = 1'b0; c = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        ok = 1'b1; d = bus.done; r = bus.resp_result; e = bus.resp_error; c = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    async_reset  = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== '0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dev_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", bus.dev_start); end
    checks++; if (bus.dev_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", bus.dev_data); end
    checks++; if (bus.grant_id !== '0) begin errors++; $display("FAIL rst_grant: got %0d want 0", bus.grant_id); end
    checks++; if (bus.resp_result !== '0 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL rst_resp: got %0d/%b want 0/0", bus.resp_result, bus.resp_error); end
    checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    async_reset = 1'b1;
  endtask

  task automatic test_single();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c; int s0;
    s0 = start_cnt;
    bus.req_data[0*DATA_W +: DATA_W] = 32'h0403_0201;
    bus.req = 4'b0001;
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0000;
    checks++; if (!ok) begin errors++; $display("FAIL t1_timeout: got no done want done"); end
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL t1_done: got %b want 0001", d); end
    checks++; if (r !== 10'd10) begin errors++; $display("FAIL t1_result: got %0d want 10", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t1_error: got %b want 0", e); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL t1_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (start_data !== 32'h0403_0201) begin errors++; $display("FAIL t1_devdata: got %h want 04030201", start_data); end
    checks++; if (c - start_cyc != 6) begin errors++; $display("FAIL t1_latency: got %0d want 6", c - start_cyc); end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_max_sum();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c;
    bus.req_data[1*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
    bus.req = 4'b0010;
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0000;
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t2_done: got %b want 0010", d); end
    checks++; if (r !== 10'd1020) begin errors++; $display("FAIL t2_result: got %0d want 1020", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t2_error: got %b want 0", e); end
  endtask

  task automatic test_round_robin();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c;
    logic [N_REQ-1:0] want;
    apply_reset();
    start_q.delete();
    exp_q.delete();
    start_cnt = 0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_data[i*DATA_W +: DATA_W] = {8'(i), 8'(i), 8'(i), 8'(i + 1)};
      exp_q.push_back(IDX_W'(i));
    end
    bus.req = 4'b1111;
    for (int k = 0; k < N_REQ; k++) begin
      wait_done(40, ok, d, r, e, c);
      want = 4'b0001 << k;
      bus.req = bus.req & ~want;
      checks++; if (!ok || d !== want) begin errors++; $display("FAIL t3_done%0d: got %b want %b", k, d, want); end
      checks++; if (r !== 10'(4 * k + 1)) begin errors++; $display("FAIL t3_result%0d: got %0d want %0d", k, r, 4 * k + 1); end
    end
    repeat (8) @(negedge clk);
    checks++; if (start_cnt != 4) begin errors++; $display("FAIL t3_starts: got %0d want 4", start_cnt); end
    checks++; if (start_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t3_order_len: got %0d want %0d", start_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (start_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t3_order%0d: got %0d want %0d", i, start_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c;
    model_on = 1'b0;
    bus.req_data[0*DATA_W +: DATA_W] = 32'h1111_1111;
    bus.req = 4'b0001;
    wait_done(60, ok, d, r, e, c);
    bus.req = 4'b0000;
    model_on = 1'b1;
    checks++; if (!ok || d !== 4'b0001) begin errors++; $display("FAIL t4_done: got %b want 0001", d); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL t4_error: got %b want 1", e); end
    checks++; if (r !== 10'd0) begin errors++; $display("FAIL t4_result: got %0d want 0", r); end
    checks++; if (c - start_cyc != 17) begin errors++; $display("FAIL t4_latency: got %0d want 17", c - start_cyc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c; int n0;
    bit seen;
    seen = 1'b0;
    bus.req_data[2*DATA_W +: DATA_W] = 32'h0A0B_0C0D;
    bus.req = 4'b0100;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.dev_start) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL t5_start: got no start want start"); end
    repeat (2) @(negedge clk);
    n0 = done_cnt;
    async_reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.state !== IDLE) begin
      errors++; $display("FAIL t5_busy: got %b/%0d want 0/0", bus.busy, bus.state); end
    checks++; if (bus.dev_data !== '0 || bus.grant_id !== '0 || bus.dev_start !== 1'b0) begin
      errors++; $display("FAIL t5_dev: got %h/%0d/%b want 0/0/0", bus.dev_data, bus.grant_id, bus.dev_start); end
    checks++; if (bus.done !== '0 || bus.resp_result !== '0 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL t5_resp: got %b/%0d/%b want 0/0/0", bus.done, bus.resp_result, bus.resp_error); end
    repeat (3) @(negedge clk);
    async_reset = 1'b1;
    checks++; if (done_cnt != n0) begin errors++; $display("FAIL t5_nodone: got %0d want %0d", done_cnt - n0, 0); end
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0000;
    checks++; if (!ok || d !== 4'b0100) begin errors++; $display("FAIL t5_done: got %b want 0100", d); end
    checks++; if (r !== 10'd46 || e !== 1'b0) begin errors++; $display("FAIL t5_result: got %0d/%b want 46/0", r, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c;
    start_q.delete();
    exp_q.delete();
    exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
    bus.req_data[1*DATA_W +: DATA_W] = 32'h0102_0304;
    bus.req_data[3*DATA_W +: DATA_W] = 32'h1020_3040;
    // serve 1 alone, then keep it requesting and add 3 (rr_ptr now 2)
    bus.req = 4'b0010;
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b1010;
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t6_first: got %b want 0010", d); end
    wait_done(40, ok, d, r, e, c);
    checks++; if (!ok || d !== 4'b1000) begin errors++; $display("FAIL t6_serve3: got %b want 1000", d); end
    checks++; if (r !== 10'd160) begin errors++; $display("FAIL t6_result3: got %0d want 160", r); end
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0010;
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t6_serve1: got %b want 0010", d); end
    // requester 1 keeps req high: it must sit out one IDLE cycle first
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0000;
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t6_again1: got %b want 0010", d); end
    checks++; if (c - start_cyc != 6) begin errors++; $display("FAIL t6_latency: got %0d want 6", c - start_cyc); end
    checks++; if (start_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t6_order_len: got %0d want %0d", start_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (start_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL t6_order%0d: got %0d want %0d", i, start_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_mask_gap();
    bit ok; logic [N_REQ-1:0] d; logic [RES_W-1:0] r; logic e; int c; int c_prev;
    bus.req = 4'b0010;
    wait_done(40, ok, d, r, e, c_prev);
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t7_first: got %b want 0010", d); end
    wait_done(40, ok, d, r, e, c);
    bus.req = 4'b0000;
    checks++; if (!ok || d !== 4'b0010) begin errors++; $display("FAIL t7_second: got %b want 0010", d); end
    // done (RESPOND) -> masked IDLE -> granting IDLE -> ISSUE
    checks++; if (start_cyc - c_prev != 3) begin errors++; $display("FAIL t7_gap: got %0d want 3", start_cyc - c_prev); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_max_sum();
    test_round_robin();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    test_mask_gap();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
